// File: rtl/disp_scan_mux.sv
// disp_scan_mux: time-multiplexed seven-segment scan engine.
// Snapshots a packed hex word once per frame, walks an active-low anode
// across NUM_DIGITS digits and presents the selected nibble, decimal point
// and blanking (digit enable / leading-zero suppression) as registered outputs.
module disp_scan_mux #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int IDXW        = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [3:0]              hex_out,
  output logic                    dp_out,
  output logic [IDXW-1:0]         sel,
  output logic                    tick
);

  localparam int DIVW = $clog2(REFRESH_DIV);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(REFRESH_DIV - 1);
  localparam logic [IDXW-1:0] SEL_LAST = IDXW'(NUM_DIGITS - 1);

  logic [DIVW-1:0]         div_cnt_q, div_cnt_d;
  logic [IDXW-1:0]         sel_q, sel_d;
  logic [4*NUM_DIGITS-1:0] snap_data_q, snap_data_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [3:0]              hex_q, hex_d;
  logic                    dp_q, dp_d;

  logic                    tick_w;
  logic                    frame_wrap;
  logic [NUM_DIGITS-1:0]   suppress;
  logic                    run_zero;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_en;
  logic                    cur_sup;
  logic                    blank;

  // Slot divider, digit index and frame snapshot next-state
  always_comb begin
    tick_w      = (div_cnt_q == DIV_LAST);
    frame_wrap  = tick_w && (sel_q == SEL_LAST);
    div_cnt_d   = tick_w ? '0 : div_cnt_q + 1'b1;
    sel_d       = sel_q;
    if (tick_w) begin
      sel_d = frame_wrap ? '0 : sel_q + 1'b1;
    end
    snap_data_d = frame_wrap ? data_in : snap_data_q;
    snap_dp_d   = frame_wrap ? dp_in   : snap_dp_q;
  end

  // Leading-zero mask: walk from the most significant digit down, digit 0 exempt
  always_comb begin
    suppress = '0;
    run_zero = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      run_zero = run_zero && (snap_data_q[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
      if (j != NUM_DIGITS - 1) begin
        suppress[NUM_DIGITS-1-j] = lz_en && run_zero;
      end
    end
  end

  // Current-digit mux and blanking decision feeding the output registers
  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_sup = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (sel_q == IDXW'(k)) begin
        cur_nib = snap_data_q[4*k +: 4];
        cur_dp  = snap_dp_q[k];
        cur_en  = digit_en[k];
        cur_sup = suppress[k];
      end
    end
    blank   = !cur_en || cur_sup;
    anode_d = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (!blank && (sel_q == IDXW'(k))) begin
        anode_d[k] = 1'b0;
      end
    end
    hex_d = cur_nib;
    dp_d  = blank ? 1'b1 : !cur_dp;
  end

  // All state; synchronous reset returns to the blank, zero-snapshot state
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      sel_q       <= '0;
      snap_data_q <= '0;
      snap_dp_q   <= '0;
      anode_q     <= '1;
      hex_q       <= '0;
      dp_q        <= 1'b1;
    end else begin
      div_cnt_q   <= div_cnt_d;
      sel_q       <= sel_d;
      snap_data_q <= snap_data_d;
      snap_dp_q   <= snap_dp_d;
      anode_q     <= anode_d;
      hex_q       <= hex_d;
      dp_q        <= dp_d;
    end
  end

  // Output drive
  always_comb begin
    anode   = anode_q;
    hex_out = hex_q;
    dp_out  = dp_q;
    sel     = sel_q;
    tick    = tick_w;
  end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux (8 digits, 4 cycles per slot).
// Expected per-cycle {anode, hex, dp} tuples are queued ahead of each frame
// and popped one per clock as the DUT produces them.
module tb_disp_scan_mux;

  localparam int ND = 8;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        lz_en;
  logic [7:0]  anode;
  logic [3:0]  hex_out;
  logic        dp_out;
  logic [2:0]  sel;
  logic        tick;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [3:0] hx;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];

  disp_scan_mux #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .dp_in   (dp_in),
    .digit_en(digit_en),
    .lz_en   (lz_en),
    .anode   (anode),
    .hex_out (hex_out),
    .dp_out  (dp_out),
    .sel     (sel),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_slot(input logic [7:0] an, input logic [3:0] hx, input logic dp);
    exp_t e;
    e.an = an;
    e.hx = hx;
    e.dp = dp;
    repeat (RD) exp_q.push_back(e);
  endtask

  // Expected slots for a frame without leading-zero suppression
  task automatic push_scan(input logic [31:0] d, input logic [7:0] dpv,
                           input logic [7:0] en, input int nslots);
    logic [7:0] onehot;
    for (int k = 0; k < nslots; k++) begin
      onehot = 8'h01 << k;
      if (en[k]) push_slot(~onehot, d[4*k +: 4], ~dpv[k]);
      else       push_slot(8'hFF,   d[4*k +: 4], 1'b1);
    end
  endtask

  task automatic run_check(input string tag, input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      step();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL %s: scoreboard empty at cycle %0d", tag, c);
      end else begin
        e = exp_q.pop_front();
        assert ({anode, hex_out, dp_out} === e) else begin
          errors++;
          $error("FAIL %s[%0d]: observed anode=%h hex=%h dp=%b expected anode=%h hex=%h dp=%b",
                 tag, c, anode, hex_out, dp_out, e.an, e.hx, e.dp);
        end
      end
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_anode"}, 32'(anode),   32'hFF);
    chk({tag, "_hex"},   32'(hex_out), 32'h0);
    chk({tag, "_dp"},    32'(dp_out),  32'h1);
    chk({tag, "_sel"},   32'(sel),     32'h0);
    chk({tag, "_tick"},  32'(tick),    32'h0);
  endtask

  // First frame after reset release: zero snapshot, first tick on cycle 3
  task automatic post_reset_frame(input string tag);
    push_scan(32'h0, 8'h00, 8'hFF, ND);
    run_check(tag, 3);
    chk({tag, "_tick3"}, 32'(tick), 32'h1);
    chk({tag, "_sel3"},  32'(sel),  32'h0);
    run_check(tag, 1);
    chk({tag, "_sel4"},  32'(sel),  32'h1);
    chk({tag, "_tick4"}, 32'(tick), 32'h0);
    run_check(tag, 28);
  endtask

  initial begin
    logic [7:0] an_tab [8];
    logic [3:0] hx_tab [8];
    an_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    hx_tab = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};

    reset    = 1'b1;
    data_in  = 32'h0;
    dp_in    = 8'h00;
    digit_en = 8'hFF;
    lz_en    = 1'b0;
    repeat (3) step();
    reset_checks("rst");

    data_in = 32'h89ABCDEF;
    dp_in   = 8'h04;
    reset   = 1'b0;
    post_reset_frame("frame1");

    // Scan order, with a mid-frame data change that must stay hidden
    for (int k = 0; k < 8; k++) push_slot(an_tab[k], hx_tab[k], (k == 2) ? 1'b0 : 1'b1);
    run_check("scan", 12);
    chk("scan_sel3", 32'(sel), 32'h3);
    data_in = 32'h12345678;
    run_check("scan", 20);

    // New word appears from digit 0 of the next frame
    push_scan(32'h12345678, 8'h04, 8'hFF, ND);
    run_check("fbuf", 1);
    lz_en   = 1'b1;
    data_in = 32'h000000A0;
    dp_in   = 8'h00;
    run_check("fbuf", 31);

    // Leading zeros above digit 1 blanked
    push_slot(8'hFE, 4'h0, 1'b1);
    push_slot(8'hFD, 4'hA, 1'b1);
    for (int k = 2; k < 8; k++) push_slot(8'hFF, 4'h0, 1'b1);
    run_check("lz_a0", 1);
    data_in = 32'h0;
    run_check("lz_a0", 31);

    // All-zero word: only digit 0 lights
    push_slot(8'hFE, 4'h0, 1'b1);
    for (int k = 1; k < 8; k++) push_slot(8'hFF, 4'h0, 1'b1);
    run_check("lz_zero", 32);
    lz_en = 1'b0;

    // Suppression off: every digit lights with 0
    push_scan(32'h0, 8'h00, 8'hFF, ND);
    run_check("lz_off", 1);
    data_in = 32'h89ABCDEF;
    dp_in   = 8'hFF;
    run_check("lz_off", 31);
    digit_en = 8'h0F;

    // Upper four digits disabled: blank anode and dp, nibble still driven
    push_scan(32'h89ABCDEF, 8'hFF, 8'h0F, ND);
    run_check("den", 32);
    digit_en = 8'hFF;

    // Reset while sel=5
    push_scan(32'h89ABCDEF, 8'hFF, 8'hFF, 5);
    run_check("pre_rst", 20);
    chk("pre_rst_sel5", 32'(sel), 32'h5);
    reset = 1'b1;
    step();
    reset_checks("mid_rst");
    reset = 1'b0;
    post_reset_frame("frame1b");
    push_scan(32'h89ABCDEF, 8'hFF, 8'hFF, ND);
    run_check("recover", 32);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan_mux.md
# disp_scan_mux

Parametrised time-multiplexed seven-segment scan engine. It takes a packed hex word of NUM_DIGITS nibbles and per-digit decimal-point requests, snapshots them once per scan frame, and walks an active-low anode through the digits at a programmable refresh rate. It outputs the selected nibble for the downstream hex-to-segment decoder. Over a fixed 8:1 nibble mux it adds digit count, refresh rate, tear-free frame buffering, per-digit enables, decimal points and leading-zero suppression.

## Interface
- NUM_DIGITS, 8: digits scanned; legal 2..16; need not be a power of two.
- REFRESH_DIV, 100000: clk cycles per digit slot; legal ≥ 2 (100000 = 1 ms/digit at 100 MHz).
- IDXW, $clog2(NUM_DIGITS): derived; not overridden.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  4*NUM_DIGITS  packed nibbles; digit i = data_in[4i+3:4i]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high.
- digit_en  in  NUM_DIGITS  per-digit enable, active-high; live, not snapshotted.
- lz_en  in  1  leading-zero suppression enable; live.
- anode  out  NUM_DIGITS  registered anode drive, active-low, at most one bit low.
- hex_out  out  4  registered nibble of the current digit.
- dp_out  out  1  registered decimal point, active-low.
- sel  out  IDXW  current digit index (slot counter).
- tick  out  1  one-cycle pulse on the last cycle of each slot.

## Operation
- Divider `div_cnt` counts 0..REFRESH_DIV-1 and wraps. `tick` = (div_cnt == REFRESH_DIV-1), combinational from the register.
- On tick: sel advances by 1, and NUM_DIGITS-1 wraps to 0. Without tick, sel holds.
- Frame buffer: `snap_data` and `snap_dp` load data_in and dp_in on the edge where tick=1 and sel=NUM_DIGITS-1, so they load together with sel wrapping to 0. Every scan therefore displays one coherent value. Input changes mid-frame never appear until the next frame.
- Leading-zero suppression: digit i is suppressed when lz_en=1, i ≥ 1, and snap nibbles i..NUM_DIGITS-1 are all 4'h0. Digit 0 is never suppressed.
- Digit k = sel is blank when digit_en[k]=0 or k is suppressed.
- Output registers, every cycle:
  - anode: all ones if blank, else ~(1 << sel).
  - hex_out: snap nibble[sel]. Driven even when blank.
  - dp_out: ~snap_dp[sel] if not blank, else 1.
- digit_en and lz_en are sampled live each cycle. A change takes effect on the next clock edge, including mid-slot.

## Timing
- Reset (synchronous, dominates everything) sets div_cnt=0, sel=0, snap_data=0, snap_dp=0, anode=all ones, hex_out=4'h0, dp_out=1. tick=0, since div_cnt=0 and REFRESH_DIV ≥ 2.
- First cycle after reset deasserts: outputs reflect digit 0 of the zero snapshot. With digit_en[0]=1, anode[0]=0 and hex_out=0.
- Output latency: anode, hex_out and dp_out follow a sel or snapshot change by exactly 1 clk. Each digit is displayed for exactly REFRESH_DIV cycles, offset 1 cycle from its sel window.
- First tick occurs REFRESH_DIV-1 cycles after reset release. Full frame = NUM_DIGITS*REFRESH_DIV cycles.
- The first frame always shows the zero snapshot. User data first appears when the slot-0 window after the first wrap begins.
- Reset mid-frame: the next edge returns to the reset state and discards the in-progress snapshot. No partial update persists.
- Non-power-of-two NUM_DIGITS: sel never takes a value ≥ NUM_DIGITS.

## Test plan
All scenarios use NUM_DIGITS=8 and REFRESH_DIV=4.
- **Reset:** hold reset 3 cycles → anode=8'hFF, dp_out=1, hex_out=0, sel=0, tick=0. After release, the first tick appears on cycle 3 and sel=1 on cycle 4.
- **Scan order:** data_in=32'h89ABCDEF, digit_en=8'hFF, lz_en=0, dp_in=8'h04, run past the first wrap → hex_out sequence F,E,D,C,B,A,9,8. Anode sequence FE,FD,FB,F7,EF,DF,BF,7F. Each value held 4 cycles. dp_out=0 only while anode=FB.
- **Frame buffer:** change data_in to 32'h12345678 while sel=3 → digits 4..7 still show B,A,9,8. The new value appears from digit 0 (hex 8) of the next frame.
- **Leading-zero suppression:**
  - lz_en=1, data_in=32'h000000A0 → anode=FF for slots 7..2; slot 1 shows A (anode FD); slot 0 shows 0 (anode FE).
  - data_in=0 → only slot 0 lights, showing 0.
  - Set lz_en=0 → all 8 slots light with 0.
- **Digit enable:** digit_en=8'h0F → anode=FF and dp_out=1 in slots 4..7. Slots 0..3 are normal.
- **Reset mid-frame:** assert reset for 1 cycle while sel=5 → on the next edge, sel=0, anode=FF, snap cleared. The following frame restarts at slot 0 with the timing of the Reset scenario.
